// File: rtl/palette_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : palette_decoder_if
//  Description : Bundle of palette-load, token-input and pixel-output signals
//                for palette_decoder. The master side loads the palette,
//                supplies tokens and consumes pixels; the slave side is the
//                decoder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface palette_decoder_if #(
    parameter int RUN_W = 4
) ();
    // Palette load
    logic              set_reg;
    logic              color_val;
    logic [23:0]       color;
    logic [3:0]        pal_count;

    // Token input
    logic              in_val;
    logic [2:0]        in_idx;
    logic [RUN_W-1:0]  in_run;
    logic              in_rdy;

    // Pixel output
    logic              out_val;
    logic [23:0]       out_color;
    logic [2:0]        out_idx;
    logic              out_last;
    logic              out_rdy;

    modport master (
        output set_reg, color_val, color,
        output in_val, in_idx, in_run,
        output out_rdy,
        input  in_rdy, out_val, out_color, out_idx, out_last, pal_count
    );

    modport slave (
        input  set_reg, color_val, color,
        input  in_val, in_idx, in_run,
        input  out_rdy,
        output in_rdy, out_val, out_color, out_idx, out_last, pal_count
    );
endinterface
`default_nettype wire

// File: rtl/palette_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : palette_decoder
//  Description : Expands (index, run) tokens into 24-bit pixels looked up in
//                an 8-entry palette. Tokens are buffered in a small FIFO and
//                each one produces run+1 pixels under valid/ready flow
//                control, back to back across token boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module palette_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int RUN_W      = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    palette_decoder_if.slave  bus
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_tok_w = 3 + RUN_W;
    localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Palette storage and load pointer
    // ------------------------------------------------------------------
    logic [23:0] r_pal [8];
    logic [2:0]  r_wp;
    logic [3:0]  r_pal_count;
    logic        w_pal_we;

    assign w_pal_we = bus.set_reg && bus.color_val;

    // Palette registers: cleared on reset, written at the load pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_pal[i] <= 24'd0;
            end
        end else if (w_pal_we) begin
            r_pal[r_wp] <= bus.color;
        end
    end

    // Load pointer restarts whenever load mode is off and sticks at the last
    // entry, so any surplus words keep overwriting entry 7
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp        <= 3'd0;
            r_pal_count <= 4'd0;
        end else if (!bus.set_reg) begin
            r_wp        <= 3'd0;
        end else if (bus.color_val) begin
            r_pal_count <= {1'b0, r_wp} + 4'd1;
            if (r_wp != 3'd7) begin
                r_wp <= r_wp + 3'd1;
            end
        end
    end

    assign bus.pal_count = r_pal_count;

    // ------------------------------------------------------------------
    // Token FIFO
    // ------------------------------------------------------------------
    logic [c_tok_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_in_rdy;
    logic               w_push;
    logic               w_pop;
    logic [c_tok_w-1:0] w_head;

    assign w_full   = (r_count == c_full_count);
    assign w_empty  = (r_count == '0);
    // Full is judged on the registered count: a same-cycle pop does not make
    // room for a push, which keeps in_rdy free of any output-side path
    assign w_in_rdy = !w_full && !bus.set_reg;
    assign w_push   = bus.in_val && w_in_rdy;
    assign w_head   = r_mem[r_rd_ptr];

    assign bus.in_rdy = w_in_rdy;

    // Token storage needs no reset: the occupancy count decides validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_idx, bus.in_run};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Run expansion FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cur_idx;
    logic [RUN_W-1:0] r_cur_cnt;
    logic             w_cnt_dec;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: fetch a token when idle, count down the run while the sink
    // accepts, and chain straight into the next token if one is waiting
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.out_rdy) begin
                    if (r_cur_cnt != '0) begin
                        w_cnt_dec = 1'b1;
                    end else if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Current token: loaded on every pop, decremented per accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_idx <= 3'd0;
            r_cur_cnt <= '0;
        end else if (w_pop) begin
            r_cur_idx <= w_head[c_tok_w-1 -: 3];
            r_cur_cnt <= w_head[RUN_W-1:0];
        end else if (w_cnt_dec) begin
            r_cur_cnt <= r_cur_cnt - RUN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pixel outputs: zeroed while no pixel is offered; colour is a live
    // palette read so a rewrite during a stall shows up immediately
    // ------------------------------------------------------------------
    logic w_emit;

    assign w_emit        = (r_state == S_EMIT);
    assign bus.out_val   = w_emit;
    assign bus.out_idx   = w_emit ? r_cur_idx : 3'd0;
    assign bus.out_color = w_emit ? r_pal[r_cur_idx] : 24'd0;
    assign bus.out_last  = w_emit && (r_cur_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_palette_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_decoder
//  Description : Self-checking bench for palette_decoder. Expected pixels are
//                queued when tokens are sent and compared against the output
//                stream; colours come from a bench-side palette model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_decoder;

    localparam int FIFO_DEPTH = 4;
    localparam int RUN_W      = 4;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
    } exp_t;

    logic clk;
    logic rst;

    palette_decoder_if #(.RUN_W(RUN_W)) bus ();

    palette_decoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RUN_W      (RUN_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks;
    int          n_errors;
    exp_t        exp_q [$];
    logic [23:0] model_pal [8];
    logic [2:0]  model_wp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every accepted pixel is compared with the queue head
    always @(negedge clk) begin
        if (!rst && bus.out_val && bus.out_rdy) begin
            if (exp_q.size() == 0) begin
                check("extra_pixel", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pix_idx", bus.out_idx, e.idx);
                check("pix_color", bus.out_color, model_pal[e.idx]);
                check("pix_last", bus.out_last, e.last);
            end
        end
    end

    // Offer one token, wait (bounded) for acceptance, queue its pixels
    task automatic send_token(input logic [2:0] idx, input logic [RUN_W-1:0] run);
        int guard = 0;
        bus.in_val = 1'b1;
        bus.in_idx = idx;
        bus.in_run = run;
        while (!bus.in_rdy && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) begin
            check("send_timeout", 1, 0);
        end
        for (int i = 0; i <= int'(run); i++) begin
            exp_q.push_back('{idx: idx, last: (i == int'(run))});
        end
        @(posedge clk);
        #1;
        bus.in_val = 1'b0;
    endtask

    // Palette write through the load protocol, mirrored into the model
    task automatic pal_write(input logic [23:0] c);
        bus.set_reg   = 1'b1;
        bus.color_val = 1'b1;
        bus.color     = c;
        @(posedge clk);
        model_pal[model_wp] = c;
        if (model_wp != 3'd7) model_wp = model_wp + 3'd1;
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model_pal[i] = 24'd0;
        model_wp = 3'd0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.set_reg   = 1'b0;
        bus.color_val = 1'b0;
        bus.color     = 24'd0;
        bus.in_val    = 1'b0;
        bus.in_idx    = 3'd0;
        bus.in_run    = '0;
        bus.out_rdy   = 1'b0;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_rdy", bus.in_rdy, 1);
        check("rst_out_val", bus.out_val, 0);
        check("rst_out_color", bus.out_color, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_pal_count", bus.pal_count, 0);

        // Load 8 colours, then a 9th that lands on entry 7
        for (int i = 0; i < 8; i++) begin
            pal_write(24'(i + 1));
        end
        check("pal_count_8", bus.pal_count, 8);
        pal_write(24'hFFFFFF);
        check("pal_count_sat", bus.pal_count, 8);
        bus.set_reg   = 1'b0;
        bus.color_val = 1'b0;
        model_wp      = 3'd0;
        @(posedge clk);
        #1;

        // Single token: two-cycle latency, three pixels
        bus.out_rdy = 1'b1;
        send_token(3'd3, 4'd2);
        check("latency_lo", bus.out_val, 0);
        @(posedge clk);
        #1;
        check("latency_hi", bus.out_val, 1);
        wait_drain("drain_single");
        check("idle_after_single", bus.out_val, 0);

        // Back-to-back tokens: no bubble across boundaries
        send_token(3'd1, 4'd0);
        send_token(3'd2, 4'd1);
        send_token(3'd5, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check("no_bubble", bus.out_val, 1);
            @(posedge clk);
            #1;
        end
        check("idle_after_b2b", bus.out_val, 0);
        wait_drain("drain_b2b");

        // Backpressure: FIFO fills, output holds, then drains in order
        bus.out_rdy = 1'b0;
        send_token(3'd7, 4'd3);
        send_token(3'd6, 4'd3);
        send_token(3'd5, 4'd3);
        send_token(3'd4, 4'd3);
        send_token(3'd3, 4'd3);
        check("full_in_rdy", bus.in_rdy, 0);
        fork
            send_token(3'd2, 4'd3);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    #1;
                    check("stall_in_rdy", bus.in_rdy, 0);
                    check("stall_out_val", bus.out_val, 1);
                    check("stall_out_idx", bus.out_idx, 7);
                    check("stall_out_color", bus.out_color, model_pal[7]);
                end
                bus.out_rdy = 1'b1;
            end
        join
        wait_drain("drain_backpressure");

        // Palette rewrite during emission
        send_token(3'd0, 4'd7);
        @(posedge clk);
        #1;
        check("emit_started", bus.out_val, 1);
        bus.set_reg   = 1'b1;
        bus.color_val = 1'b1;
        bus.color     = 24'hABCDEF;
        #1;
        check("set_reg_blocks", bus.in_rdy, 0);
        @(posedge clk);
        model_pal[0] = 24'hABCDEF;
        #1;
        check("live_color", bus.out_color, 24'hABCDEF);
        check("emit_continues", bus.out_val, 1);
        check("pal_count_1", bus.pal_count, 1);
        bus.set_reg   = 1'b0;
        bus.color_val = 1'b0;
        wait_drain("drain_rewrite");

        // Asynchronous reset mid-run with tokens queued
        bus.out_rdy = 1'b0;
        send_token(3'd4, 4'd5);
        send_token(3'd1, 4'd2);
        send_token(3'd2, 4'd2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_val", bus.out_val, 0);
        check("mid_rst_out_color", bus.out_color, 0);
        check("mid_rst_pal_count", bus.pal_count, 0);
        check("mid_rst_in_rdy", bus.in_rdy, 1);
        exp_q.delete();
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("no_residual", bus.out_val, 0);

        // Cleared palette: a fresh token reads back zero colour
        send_token(3'd3, 4'd0);
        wait_drain("drain_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
